// File: rtl/text_cursor_writer.sv
// Cursor-tracking character writer: turns classified key events into registered RAM writes
// over a COLS x ROWS grid, optionally blanking each newly entered row before taking more keys.
module text_cursor_writer #(
    parameter int                COLS    = 80,
    parameter int                ROWS    = 48,
    parameter int                DATA_W  = 8,
    parameter int                TAB_W   = 8,
    parameter logic [DATA_W-1:0] BLANK   = 8'h20,
    parameter bit                CLR_ROW = 1'b1,
    parameter int                AW      = $clog2(COLS*ROWS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key_valid,
    output logic                      key_ready,
    input  logic [1:0]                key_kind,
    input  logic [DATA_W-1:0]         key_code,
    output logic                      wr_en,
    output logic [AW-1:0]             wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [$clog2(COLS)-1:0]   col,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic                      busy
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    localparam logic [CW-1:0] ColMax = CW'(COLS - 1);
    localparam logic [RW-1:0] RowMax = RW'(ROWS - 1);
    localparam logic [AW-1:0] ColsA  = AW'(COLS);

    localparam logic [1:0] KindPrint = 2'b00;
    localparam logic [1:0] KindEnter = 2'b01;
    localparam logic [1:0] KindTab   = 2'b10;
    localparam logic [1:0] KindBack  = 2'b11;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     k_q, k_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic          accept;
    logic          advance;
    logic [RW-1:0] row_adv;
    logic [AW-1:0] row_base;
    logic [AW-1:0] prev_base;
    logic [31:0]   tab_stop;

    assign accept = key_valid && (state_q == StIdle);

    always_comb begin
        row_adv   = (row_q == RowMax) ? '0 : row_q + 1'b1;
        row_base  = AW'(row_q) * ColsA;
        prev_base = AW'(row_q - 1'b1) * ColsA;
        // Computed at 32 bits so the next stop past the last column cannot alias.
        tab_stop  = (32'(col_q) / 32'(TAB_W) + 32'd1) * 32'(TAB_W);
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        k_d       = k_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        advance   = 1'b0;

        if (state_q == StClear) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base + AW'(k_q);
            wr_data_d = BLANK;
            if (k_q == ColMax) begin
                state_d = StIdle;
                k_d     = '0;
            end else begin
                k_d = k_q + 1'b1;
            end
        end else if (accept) begin
            unique case (key_kind)
                KindPrint: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base + AW'(col_q);
                    wr_data_d = key_code;
                    if (col_q == ColMax) begin
                        advance = 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                KindEnter: advance = 1'b1;
                KindTab: begin
                    if (tab_stop >= 32'(COLS)) begin
                        advance = 1'b1;
                    end else begin
                        col_d = CW'(tab_stop);
                    end
                end
                KindBack: begin
                    if (col_q != '0) begin
                        col_d     = col_q - 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_base + AW'(col_q - 1'b1);
                        wr_data_d = BLANK;
                    end else if (row_q != '0) begin
                        row_d     = row_q - 1'b1;
                        col_d     = ColMax;
                        wr_en_d   = 1'b1;
                        wr_addr_d = prev_base + AW'(ColMax);
                        wr_data_d = BLANK;
                    end
                end
                default: ;
            endcase

            if (advance) begin
                col_d = '0;
                row_d = row_adv;
                if (CLR_ROW) begin
                    state_d = StClear;
                    k_d     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            k_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            k_q       <= k_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign key_ready = (state_q == StIdle);
    assign busy      = (state_q == StClear);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign col       = col_q;
    assign row       = row_q;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer: three instances cover the 80x48 default grid,
// a tiny 4x2 clearing grid, and an 8x3 grid with row clearing disabled.
module tb_text_cursor_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] kind = 2'b00;
    logic [7:0] code = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    int         checks = 0;
    int         failures = 0;

    logic        kr0, we0, busy0;
    logic [11:0] wa0;
    logic [7:0]  wd0;
    logic [6:0]  col0;
    logic [5:0]  row0;

    logic        kr1, we1, busy1;
    logic [2:0]  wa1;
    logic [7:0]  wd1;
    logic [1:0]  col1;
    logic [0:0]  row1;

    logic        kr2, we2, busy2;
    logic [4:0]  wa2;
    logic [7:0]  wd2;
    logic [2:0]  col2;
    logic [1:0]  row2;

    always #5 clk = ~clk;

    text_cursor_writer #(.COLS(80), .ROWS(48), .DATA_W(8), .TAB_W(8), .BLANK(8'h20),
                         .CLR_ROW(1'b1)) dut0 (
        .clk(clk), .rst(rst), .key_valid(v0), .key_ready(kr0), .key_kind(kind),
        .key_code(code), .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .col(col0),
        .row(row0), .busy(busy0));

    text_cursor_writer #(.COLS(4), .ROWS(2), .CLR_ROW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .key_valid(v1), .key_ready(kr1), .key_kind(kind),
        .key_code(code), .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .col(col1),
        .row(row1), .busy(busy1));

    text_cursor_writer #(.COLS(8), .ROWS(3), .CLR_ROW(1'b0)) dut2 (
        .clk(clk), .rst(rst), .key_valid(v2), .key_ready(kr2), .key_kind(kind),
        .key_code(code), .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .col(col2),
        .row(row2), .busy(busy2));

    // Present one event to the selected instance for exactly one edge; returns #1 after it.
    task automatic send(input int which, input logic [1:0] k, input logic [7:0] c);
        @(negedge clk);
        kind = k;
        code = c;
        v0 = (which == 0);
        v1 = (which == 1);
        v2 = (which == 2);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (we0 !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0b want=0", we0); end
        checks++; if (wa0 !== 12'd0) begin failures++; $display("FAIL rst_wr_addr got=%0d want=0", wa0); end
        checks++; if (wd0 !== 8'h00) begin failures++; $display("FAIL rst_wr_data got=%0h want=0", wd0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b want=0", busy0); end
        checks++; if (kr0 !== 1'b1) begin failures++; $display("FAIL rst_key_ready got=%0b want=1", kr0); end
        checks++; if (col0 !== 7'd0 || row0 !== 6'd0) begin failures++;
            $display("FAIL rst_cursor got=(%0d,%0d) want=(0,0)", row0, col0); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_printable();
        send(0, 2'b00, 8'h41);
        checks++; if (we0 !== 1'b1) begin failures++; $display("FAIL pr_wr_en got=%0b want=1", we0); end
        checks++; if (wa0 !== 12'd0) begin failures++; $display("FAIL pr_wr_addr got=%0d want=0", wa0); end
        checks++; if (wd0 !== 8'h41) begin failures++; $display("FAIL pr_wr_data got=%0h want=41", wd0); end
        checks++; if (col0 !== 7'd1) begin failures++; $display("FAIL pr_col got=%0d want=1", col0); end
        checks++; if (kr0 !== 1'b1) begin failures++; $display("FAIL pr_key_ready got=%0b want=1", kr0); end
        tick();
        checks++; if (we0 !== 1'b0) begin failures++; $display("FAIL pr_pulse got=%0b want=0", we0); end
    endtask

    task automatic test_tab();
        send(0, 2'b00, 8'h42);
        send(0, 2'b00, 8'h43);
        checks++; if (wa0 !== 12'd2) begin failures++; $display("FAIL tab_pre_addr got=%0d want=2", wa0); end
        send(0, 2'b10, 8'h00);
        checks++; if (col0 !== 7'd8) begin failures++; $display("FAIL tab_col got=%0d want=8", col0); end
        checks++; if (we0 !== 1'b0) begin failures++; $display("FAIL tab_wr_en got=%0b want=0", we0); end
        for (int i = 0; i < 8; i++) send(0, 2'b10, 8'h00);
        checks++; if (col0 !== 7'd72) begin failures++; $display("FAIL tab_col72 got=%0d want=72", col0); end
        for (int i = 0; i < 5; i++) send(0, 2'b00, 8'h78);
        checks++; if (col0 !== 7'd77 || wa0 !== 12'd76) begin failures++;
            $display("FAIL tab_col77 got=col %0d addr %0d want=col 77 addr 76", col0, wa0); end
        send(0, 2'b10, 8'h00);
        checks++; if (col0 !== 7'd0 || row0 !== 6'd1) begin failures++;
            $display("FAIL tabwrap_cursor got=(%0d,%0d) want=(1,0)", row0, col0); end
        checks++; if (we0 !== 1'b0) begin failures++; $display("FAIL tabwrap_wr_en got=%0b want=0", we0); end
        checks++; if (busy0 !== 1'b1 || kr0 !== 1'b0) begin failures++;
            $display("FAIL tabwrap_busy got=busy %0b ready %0b want=busy 1 ready 0", busy0, kr0); end
        // Hold a key through the clear; it must wait until the clear finishes.
        @(negedge clk);
        kind = 2'b00;
        code = 8'h5A;
        v0   = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            checks++;
            if (we0 !== 1'b1 || wa0 !== 12'(80 + i) || wd0 !== 8'h20 || busy0 !== (i < 79)) begin
                failures++;
                $display("FAIL clear_%0d got=en %0b addr %0d data %0h busy %0b want=en 1 addr %0d data 20 busy %0b",
                         i, we0, wa0, wd0, busy0, 80 + i, (i < 79));
            end
        end
        tick();
        v0 = 1'b0;
        checks++; if (we0 !== 1'b1 || wa0 !== 12'd80 || wd0 !== 8'h5A || col0 !== 7'd1) begin failures++;
            $display("FAIL held_key got=en %0b addr %0d data %0h col %0d want=en 1 addr 80 data 5a col 1",
                     we0, wa0, wd0, col0); end
    endtask

    task automatic test_backspace();
        send(0, 2'b11, 8'h00);
        checks++; if (we0 !== 1'b1 || wa0 !== 12'd80 || wd0 !== 8'h20 || col0 !== 7'd0) begin failures++;
            $display("FAIL bs_col1 got=en %0b addr %0d data %0h col %0d want=en 1 addr 80 data 20 col 0",
                     we0, wa0, wd0, col0); end
        send(0, 2'b11, 8'h00);
        checks++; if (row0 !== 6'd0 || col0 !== 7'd79) begin failures++;
            $display("FAIL bs_line_cursor got=(%0d,%0d) want=(0,79)", row0, col0); end
        checks++; if (we0 !== 1'b1 || wa0 !== 12'd79 || wd0 !== 8'h20) begin failures++;
            $display("FAIL bs_line_write got=en %0b addr %0d data %0h want=en 1 addr 79 data 20",
                     we0, wa0, wd0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL bs_line_busy got=%0b want=0", busy0); end
        send(0, 2'b11, 8'h00);
        checks++; if (wa0 !== 12'd78 || col0 !== 7'd78) begin failures++;
            $display("FAIL bs_78 got=addr %0d col %0d want=addr 78 col 78", wa0, col0); end
        do_reset();
        send(0, 2'b11, 8'h00);
        checks++; if (we0 !== 1'b0 || col0 !== 7'd0 || row0 !== 6'd0) begin failures++;
            $display("FAIL bs_origin got=en %0b (%0d,%0d) want=en 0 (0,0)", we0, row0, col0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(0, 2'b00, 8'(8'h61 + i));
            checks++; if (we0 !== 1'b1 || wa0 !== 12'(i) || wd0 !== 8'(8'h61 + i)) begin failures++;
                $display("FAIL b2b_%0d got=en %0b addr %0d data %0h want=en 1 addr %0d data %0h",
                         i, we0, wa0, wd0, i, 8'h61 + i); end
        end
        checks++; if (col0 !== 7'd3) begin failures++; $display("FAIL b2b_col got=%0d want=3", col0); end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        send(0, 2'b01, 8'h00);
        checks++; if (we0 !== 1'b0 || busy0 !== 1'b1 || row0 !== 6'd1) begin failures++;
            $display("FAIL enter got=en %0b busy %0b row %0d want=en 0 busy 1 row 1", we0, busy0, row0); end
        repeat (10) tick();
        checks++; if (we0 !== 1'b1 || wa0 !== 12'd89) begin failures++;
            $display("FAIL midclr_pre got=en %0b addr %0d want=en 1 addr 89", we0, wa0); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (we0 !== 1'b0 || busy0 !== 1'b0 || kr0 !== 1'b1) begin failures++;
            $display("FAIL midclr_rst got=en %0b busy %0b ready %0b want=en 0 busy 0 ready 1",
                     we0, busy0, kr0); end
        checks++; if (col0 !== 7'd0 || row0 !== 6'd0) begin failures++;
            $display("FAIL midclr_cursor got=(%0d,%0d) want=(0,0)", row0, col0); end
        @(negedge clk);
        rst = 1'b0;
        send(0, 2'b00, 8'h51);
        checks++; if (we0 !== 1'b1 || wa0 !== 12'd0 || wd0 !== 8'h51) begin failures++;
            $display("FAIL midclr_next got=en %0b addr %0d data %0h want=en 1 addr 0 data 51",
                     we0, wa0, wd0); end
    endtask

    task automatic test_small_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(1, 2'b00, 8'(8'h30 + i));
            checks++; if (we1 !== 1'b1 || wa1 !== 3'(i) || wd1 !== 8'(8'h30 + i)) begin failures++;
                $display("FAIL small_char_%0d got=en %0b addr %0d data %0h want=en 1 addr %0d data %0h",
                         i, we1, wa1, wd1, i, 8'h30 + i); end
            if (i == 3 || i == 7) begin
                checks++; if (kr1 !== 1'b0) begin failures++;
                    $display("FAIL small_ready_%0d got=%0b want=0", i, kr1); end
                for (int j = 0; j < 4; j++) begin
                    tick();
                    checks++;
                    if (we1 !== 1'b1 || wa1 !== 3'((i == 3 ? 4 : 0) + j) || wd1 !== 8'h20) begin
                        failures++;
                        $display("FAIL small_clr_%0d_%0d got=en %0b addr %0d data %0h want=en 1 addr %0d data 20",
                                 i, j, we1, wa1, wd1, (i == 3 ? 4 : 0) + j);
                    end
                end
            end
        end
        checks++; if (col1 !== 2'd0 || row1 !== 1'd0 || busy1 !== 1'b0 || kr1 !== 1'b1) begin failures++;
            $display("FAIL small_end got=(%0d,%0d) busy %0b ready %0b want=(0,0) busy 0 ready 1",
                     row1, col1, busy1, kr1); end
    endtask

    task automatic test_no_clear();
        do_reset();
        send(2, 2'b00, 8'h78);
        checks++; if (we2 !== 1'b1 || wa2 !== 5'd0 || col2 !== 3'd1) begin failures++;
            $display("FAIL nc_char got=en %0b addr %0d col %0d want=en 1 addr 0 col 1", we2, wa2, col2); end
        for (int i = 1; i <= 3; i++) begin
            send(2, 2'b01, 8'h00);
            checks++;
            if (we2 !== 1'b0 || kr2 !== 1'b1 || busy2 !== 1'b0 || col2 !== 3'd0 || row2 !== 2'(i % 3)) begin
                failures++;
                $display("FAIL nc_enter_%0d got=en %0b ready %0b busy %0b (%0d,%0d) want=en 0 ready 1 busy 0 (%0d,0)",
                         i, we2, kr2, busy2, row2, col2, i % 3);
            end
        end
        tick();
        checks++; if (we2 !== 1'b0 || kr2 !== 1'b1) begin failures++;
            $display("FAIL nc_idle got=en %0b ready %0b want=en 0 ready 1", we2, kr2); end
    endtask

    initial begin
        test_reset();
        test_printable();
        test_tab();
        test_backspace();
        test_back_to_back();
        test_reset_mid_clear();
        test_small_wrap();
        test_no_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_cursor_writer.md
# text_cursor_writer

Parametrised text-buffer writer that sits between the PS/2 keyboard controller and the dual-port character RAM. It accepts classified key events (printable, enter, tab, backspace) and maintains a cursor over a COLS x ROWS grid. It issues single-cycle RAM write commands, handling tab stops, line wrap, backspace across lines and optional clearing of each newly entered row. It replaces the free-running column/row counter pair and address adder with one handshaked block.

## Interface

Parameters:
- COLS, 80, characters per row (>= 2)
- ROWS, 48, rows in the buffer (>= 2)
- DATA_W, 8, character code width
- TAB_W, 8, tab-stop spacing in columns (>= 1)
- BLANK, 8'h20, code written by backspace and row clear (DATA_W wide)
- CLR_ROW, 1, 1 = blank every newly entered row; 0 = never clear
- AW, $clog2(COLS*ROWS), derived write-address width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  key event present
- key_ready  out  1  block can accept an event this cycle
- key_kind  in  2  00 printable, 01 enter, 10 tab, 11 backspace
- key_code  in  DATA_W  character code; used only for printable
- wr_en  out  1  RAM write strobe, registered
- wr_addr  out  AW  RAM address = row*COLS + col, registered
- wr_data  out  DATA_W  RAM data, registered
- col  out  $clog2(COLS)  current cursor column
- row  out  $clog2(ROWS)  current cursor row
- busy  out  1  high while in CLEAR

## Operation

- Clock is clk; reset is asynchronous and active-high on rst.
- States:
  - IDLE: key_ready=1, busy=0.
  - CLEAR: key_ready=0, busy=1.
- Event accepted on an edge where key_valid && key_ready. All effects below take place on that edge.
- Printable:
  - Write key_code at (row,col).
  - If col < COLS-1, col+1. Otherwise col=0 and a row advance.
- Enter: no write. col=0 and a row advance.
- Tab:
  - No write. col' = (col/TAB_W+1)*TAB_W.
  - If col' >= COLS, col=0 and a row advance. Otherwise col=col'.
- Backspace:
  - col > 0: col-1 and write BLANK at (row,col-1).
  - col == 0 and row > 0: row-1, col=COLS-1, write BLANK at (row-1,COLS-1).
  - col == 0 and row == 0: no write, no move.
- Row advance:
  - row = (row==ROWS-1) ? 0 : row+1.
  - If CLR_ROW=1, next state is CLEAR with internal index k=0.
- CLEAR:
  - Each edge registers a write of BLANK at newrow*COLS+k, then k+1.
  - The edge with k==COLS-1 returns to IDLE.
  - Cursor stays at (newrow,0) throughout.
- key_kind other than printable ignores key_code. Events presented while key_ready=0 are not consumed; the source holds them.
- Address arithmetic is full width. Product row*COLS + col never exceeds COLS*ROWS-1.

## Timing

- Reset values:
  - state IDLE, col=0, row=0, k=0.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, key_ready=1.
  - Values apply immediately on rst assertion, including mid-CLEAR (the clear is abandoned).
- wr_en is a one-cycle pulse per write.
  - Event accepted at edge N: write visible in cycle N..N+1 (after edge N).
  - wr_en=0 on edges that issue no write.
- col/row are registered and reflect the update after edge N.
- Printable at col=COLS-1 with CLR_ROW=1:
  - char write after edge N.
  - Clear writes after edges N+1..N+COLS.
  - wr_en high for COLS+1 consecutive cycles.
  - key_ready low after edge N until after edge N+COLS.
- Enter or tab-wrap with CLR_ROW=1: no write after edge N; COLS clear writes after edges N+1..N+COLS.
- Back-to-back events in IDLE: one accepted per cycle, one write per cycle maximum.

## Test plan

- Reset, COLS=80: printable 'A' (8'h41) at (0,0) -> wr_en 1 cycle, wr_addr=0, wr_data=41; col=1; key_ready stays 1.
- Tab from col=3, TAB_W=8 -> col=8, no wr_en. Tab from col=77 -> col=0, row=1, then 80 BLANK writes to addr 80..159 with busy=1, key_ready=0.
- Backspace at (1,0) -> row=0, col=79, single write BLANK addr 79. Backspace at (0,0) -> no write, cursor unchanged.
- COLS=4, ROWS=2, CLR_ROW=1, 8 printables -> writes addr 0..7 interleaved with row clears. The 8th wraps to row 0 and clears addr 0..3; cursor (0,0).
- CLR_ROW=0, enter at row=ROWS-1 -> row=0, col=0, no writes, key_ready never drops.
- Assert rst mid-CLEAR (k=10) -> wr_en=0, busy=0, col=row=0 immediately. Next printable writes addr 0.
